ftc_issue: RTL
==============

Name: ftc_issue

Overview:
- Issue stage that drives the fetch-to-decode interface of the CUES token pipeline.
- Accepts fetched instruction tokens through a valid/ready handshake and buffers them in a small FIFO.
- Merges memory-write requests into the same stream, and registers one packet per cycle toward the decoder.
- The decoder has no valid or stall input, so this block emits an all-zero NOP bubble whenever it has nothing to issue.

Parameters:
- DEPTH, 4, token FIFO entries (power of 2, minimum 2).
- MEM_BURST, 3, maximum consecutive memory-write slots while tokens are waiting; must be 1 or greater.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- tok_valid_i  in  1  fetched token valid.
- tok_ready_o  out  1  token accepted when tok_valid_i and tok_ready_o are both 1.
- tok_node_i  in  16  token node id.
- tok_gen_i  in  12  token generation.
- tok_opr0_i  in  32  operand 0.
- tok_opr1_i  in  32  operand 1.
- tok_ins_i  in  34  instruction: [33:27] opcode, [26:0] fields.
- mem_valid_i  in  1  memory-write request valid.
- mem_ready_o  out  1  memory request accepted when mem_valid_i and mem_ready_o are both 1.
- mem_node_i  in  16  node id for the write.
- mem_gen_i  in  12  generation for the write.
- mem_addr_i  in  32  write address, carried on opr0.
- mem_data_i  in  32  write data, carried on opr1.
- node_o  out  16  packet node to decode.
- gen_o  out  12  packet generation.
- opr0_o  out  32  packet operand 0.
- opr1_o  out  32  packet operand 1.
- mem_wen_o  out  1  packet is a memory write.
- ins_o  out  34  packet instruction.
- issue_vld_o  out  1  packet is not a bubble (debug/verification only).
- fifo_cnt_o  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset and clocking
  - Everything is sampled on posedge clk. Reset applies when rst==0 at the edge.
  - On reset: FIFO is emptied (read/write pointers and count = 0) and the burst counter = 0.
  - All output registers reset to 0. As a result, tok_ready_o=1 and mem_ready_o=1 in the first cycle after reset.
  - Reset mid-operation discards all buffered tokens, including any token offered on that edge.
- Handshakes
  - tok_ready_o = (count < DEPTH). It depends only on registered state; there is no combinational path from tok_valid_i.
  - mem_ready_o = !(count != 0 && burst_cnt == MEM_BURST).
- Issue selection, once per edge; exactly one of the following loads the output register:
  - Memory slot: mem_valid_i && mem_ready_o.
    - Outputs: node/gen from mem_*, opr0_o=mem_addr_i, opr1_o=mem_data_i, mem_wen_o=1, ins_o=0, issue_vld_o=1.
  - Token slot: otherwise, if count != 0, pop the FIFO head.
    - Outputs: node/gen/opr0/opr1/ins from the head, mem_wen_o=0, issue_vld_o=1.
  - Bubble: otherwise, all packet outputs are 0, mem_wen_o=0, issue_vld_o=0.
- Burst counter
  - Increments on a memory slot taken while count != 0.
  - Clears on a token slot or whenever count == 0.
  - When burst_cnt == MEM_BURST with tokens waiting, memory is stalled for exactly one cycle and the head token issues.
- FIFO
  - Push on token handshake; pop on token slot. Push and pop can occur on the same edge.
  - Simultaneous push+pop leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
  - There is no bypass: a token accepted at edge N is visible on the outputs after edge N+1 at the earliest.
  - Full (count==DEPTH): no push on that edge even if a pop occurs; tok_ready_o rises the cycle after the pop.
- Latency and ordering
  - Memory requests are visible after the accepting edge (latency 1).
  - Token order is strictly FIFO. Memory requests are never buffered; a stalled request is held by its source.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, tok_ready_o=1, mem_ready_o=1, fifo_cnt_o=0.
- Single token (node=0x0012, gen=0x003, ins=0x1_2345_6789) accepted at edge 1, no mem traffic → packet on outputs after edge 2 with mem_wen_o=0, issue_vld_o=1; bubble after edge 3.
- 6 back-to-back tokens with DEPTH=4 and mem_valid_i held 1 (MEM_BURST=3):
  - tok_ready_o drops at count=4.
  - Output sequence is M,M,M,T0,M,M,M,T1…
  - mem_ready_o=0 exactly on the T cycles.
  - Tokens appear in order.
- Full FIFO, simultaneous push attempt and pop → push rejected, count=3 after the edge, tok_ready_o=1 next cycle, no token lost or duplicated.
- Memory request alone (addr=0x0000_0100, data=0xDEAD_BEEF) → after one edge: opr0_o=0x100, opr1_o=0xDEADBEEF, mem_wen_o=1, ins_o=0.
- rst=0 for one edge with 3 tokens buffered → count=0, outputs 0, and subsequent tokens issue in order starting from the first post-reset token.

Source files
------------

// File: rtl/ftc_issue.sv
// Issue stage for the CUES fetch-to-decode interface: buffers fetched tokens in a
// small FIFO, merges memory-write requests and registers one packet (or NOP bubble) per cycle.
module ftc_issue #(
   parameter int DEPTH     = 4,
   parameter int MEM_BURST = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tok_valid_i,
   output logic                       tok_ready_o,
   input  logic [15:0]                tok_node_i,
   input  logic [11:0]                tok_gen_i,
   input  logic [31:0]                tok_opr0_i,
   input  logic [31:0]                tok_opr1_i,
   input  logic [33:0]                tok_ins_i,
   input  logic                       mem_valid_i,
   output logic                       mem_ready_o,
   input  logic [15:0]                mem_node_i,
   input  logic [11:0]                mem_gen_i,
   input  logic [31:0]                mem_addr_i,
   input  logic [31:0]                mem_data_i,
   output logic [15:0]                node_o,
   output logic [11:0]                gen_o,
   output logic [31:0]                opr0_o,
   output logic [31:0]                opr1_o,
   output logic                       mem_wen_o,
   output logic [33:0]                ins_o,
   output logic                       issue_vld_o,
   output logic [$clog2(DEPTH):0]     fifo_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int BW = $clog2(MEM_BURST + 1);
   localparam int TW = 16 + 12 + 32 + 32 + 34;

   logic [TW-1:0] fifo_q [DEPTH];
   logic [TW-1:0] fifo_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] burst_q, burst_d;

   logic [15:0]   node_q, node_d;
   logic [11:0]   gen_q, gen_d;
   logic [31:0]   opr0_q, opr0_d;
   logic [31:0]   opr1_q, opr1_d;
   logic          wen_q, wen_d;
   logic [33:0]   ins_q, ins_d;
   logic          vld_q, vld_d;

   logic          fifo_empty;
   logic          push;
   logic          mem_slot;
   logic          tok_slot;
   logic [TW-1:0] head;

   assign fifo_empty  = (cnt_q == '0);
   assign tok_ready_o = (cnt_q < CW'(DEPTH));
   // Memory loses priority for one cycle once it has held off waiting tokens MEM_BURST times.
   assign mem_ready_o = !(!fifo_empty && (burst_q == BW'(MEM_BURST)));
   assign push        = tok_valid_i && tok_ready_o;
   assign mem_slot    = mem_valid_i && mem_ready_o;
   assign tok_slot    = !mem_slot && !fifo_empty;
   assign head        = fifo_q[rd_ptr_q];

   always_comb begin
      for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {tok_node_i, tok_gen_i, tok_opr0_i, tok_opr1_i, tok_ins_i};
         wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (tok_slot) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, tok_slot};
   end

   always_comb begin
      burst_d = burst_q;
      if (fifo_empty || tok_slot) burst_d = '0;
      else if (mem_slot)          burst_d = burst_q + BW'(1);
   end

   always_comb begin
      node_d = '0;
      gen_d  = '0;
      opr0_d = '0;
      opr1_d = '0;
      wen_d  = 1'b0;
      ins_d  = '0;
      vld_d  = 1'b0;
      if (mem_slot) begin
         node_d = mem_node_i;
         gen_d  = mem_gen_i;
         opr0_d = mem_addr_i;
         opr1_d = mem_data_i;
         wen_d  = 1'b1;
         vld_d  = 1'b1;
      end else if (tok_slot) begin
         {node_d, gen_d, opr0_d, opr1_d, ins_d} = head;
         vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         burst_q  <= '0;
         node_q   <= '0;
         gen_q    <= '0;
         opr0_q   <= '0;
         opr1_q   <= '0;
         wen_q    <= 1'b0;
         ins_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         burst_q  <= burst_d;
         node_q   <= node_d;
         gen_q    <= gen_d;
         opr0_q   <= opr0_d;
         opr1_q   <= opr1_d;
         wen_q    <= wen_d;
         ins_q    <= ins_d;
         vld_q    <= vld_d;
      end
   end

   assign node_o      = node_q;
   assign gen_o       = gen_q;
   assign opr0_o      = opr0_q;
   assign opr1_o      = opr1_q;
   assign mem_wen_o   = wen_q;
   assign ins_o       = ins_q;
   assign issue_vld_o = vld_q;
   assign fifo_cnt_o  = cnt_q;

endmodule
